interp_pixel_fetch: RTL

INTERP_PIXEL_FETCH -- requirements
Module: interp_pixel_fetch

---
 rtl/interp_pixel_fetch.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/interp_pixel_fetch.sv
// interp_pixel_fetch: fetches the 2x2 neighbourhood around a fixed-point source coordinate
// from frame RAM with fixed latency. Define FETCH_EDGE_CLAMP_EN to clamp edge neighbours instead of substituting BORDER_VAL.
module interp_pixel_fetch #(
    parameter int         IMG_W      = 640,
    parameter int         IMG_H      = 480,
    parameter int         ADDR_WIDTH = 19,
    parameter logic [7:0] BORDER_VAL = 8'd0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [15:0]           in_x,
    input  logic [15:0]           in_y,
    output logic                  mem_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [7:0]            mem_rdata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [5:0]            dx,
    output logic [5:0]            dy,
    output logic [7:0]            lu,
    output logic [7:0]            ru,
    output logic [7:0]            ld,
    output logic [7:0]            rd
);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, OUT} state_t;

    localparam logic [10:0]           IMG_W_C    = 11'(IMG_W);
    localparam logic [10:0]           IMG_H_C    = 11'(IMG_H);
    localparam logic [ADDR_WIDTH-1:0] ROW_STRIDE = ADDR_WIDTH'(IMG_W);

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [10:0] x0_q, x0_d;
    logic [10:0] y0_q, y0_d;
    logic [5:0]  dx_q, dx_d;
    logic [5:0]  dy_q, dy_d;
    logic [7:0]  lu_q, lu_d;
    logic [7:0]  ru_q, ru_d;
    logic [7:0]  ld_q, ld_d;
    logic [7:0]  rd_q, rd_d;

    logic        outside;
    logic        xEdge;
    logic        yEdge;
    logic [10:0] xRight;
    logic [10:0] yDown;
    logic [10:0] xN;
    logic [10:0] yN;
    logic [3:0]  slotBorder;
    logic [1:0]  capSel;
    logic [7:0]  capVal;
    logic        capEn;

    // slotBorder[i] marks neighbour i (lu, ru, ld, rd) as substituted rather than read.
    always_comb begin
        outside = (x0_q >= IMG_W_C) || (y0_q >= IMG_H_C);
        xEdge   = (x0_q == IMG_W_C - 11'd1);
        yEdge   = (y0_q == IMG_H_C - 11'd1);
`ifdef FETCH_EDGE_CLAMP_EN
        xRight     = xEdge ? x0_q : x0_q + 11'd1;
        yDown      = yEdge ? y0_q : y0_q + 11'd1;
        slotBorder = {4{outside}};
`else
        xRight     = x0_q + 11'd1;
        yDown      = y0_q + 11'd1;
        slotBorder = {outside | xEdge | yEdge, outside | yEdge, outside | xEdge, outside};
`endif
        xN = cnt_q[0] ? xRight : x0_q;
        yN = cnt_q[1] ? yDown : y0_q;
    end

    assign mem_addr = ADDR_WIDTH'(yN) * ROW_STRIDE + ADDR_WIDTH'(xN);
    assign mem_en   = (state_q == FETCH) && !slotBorder[cnt_q];

    // Read data lags its issue by one cycle, so the slot captured is the one issued last cycle.
    always_comb begin
        capSel = (state_q == DRAIN) ? 2'd3 : cnt_q - 2'd1;
        capEn  = ((state_q == FETCH) && (cnt_q != 2'd0)) || (state_q == DRAIN);
        capVal = slotBorder[capSel] ? BORDER_VAL : mem_rdata;
    end

    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = (state_q == OUT);
    assign dx = dx_q;
    assign dy = dy_q;
    assign lu = lu_q;
    assign ru = ru_q;
    assign ld = ld_q;
    assign rd = rd_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x0_d    = x0_q;
        y0_d    = y0_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        lu_d    = lu_q;
        ru_d    = ru_q;
        ld_d    = ld_q;
        rd_d    = rd_q;
        if (capEn) begin
            case (capSel)
                2'd0:    lu_d = capVal;
                2'd1:    ru_d = capVal;
                2'd2:    ld_d = capVal;
                default: rd_d = capVal;
            endcase
        end
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    x0_d    = {1'b0, in_x[15:6]};
                    y0_d    = {1'b0, in_y[15:6]};
                    dx_d    = in_x[5:0];
                    dy_d    = in_y[5:0];
                    cnt_d   = 2'd0;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                state_d = OUT;
            end
            OUT: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
            x0_q    <= 11'd0;
            y0_q    <= 11'd0;
            dx_q    <= 6'd0;
            dy_q    <= 6'd0;
            lu_q    <= 8'd0;
            ru_q    <= 8'd0;
            ld_q    <= 8'd0;
            rd_q    <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x0_q    <= x0_d;
            y0_q    <= y0_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            lu_q    <= lu_d;
            ru_q    <= ru_d;
            ld_q    <= ld_d;
            rd_q    <= rd_d;
        end
    end

endmodule
